// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp compare and msip,
// exposed over a Wishbone-classic slave with a single-cycle registered ack.
module machine_timer #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              timer_irq,
    output logic              soft_irq
);

    typedef enum logic [2:0] {
        OFF_MTIME_LO = 3'd0,
        OFF_MTIME_HI = 3'd1,
        OFF_CMP_LO   = 3'd2,
        OFF_CMP_HI   = 3'd3,
        OFF_CTRL     = 3'd4,
        OFF_MSIP     = 3'd5,
        OFF_RSVD6    = 3'd6,
        OFF_RSVD7    = 3'd7
    } reg_off_e;

    logic [31:0] r_mtime_lo;
    logic [31:0] r_mtime_hi;
    logic [63:0] r_cmp;
    logic        r_en;
    logic [7:0]  r_div;
    logic [7:0]  r_pcnt;
    logic        r_msip;
    logic [31:0] r_hi_shadow;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_tirq;

    reg_off_e    w_off;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_rdata;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_off    = reg_off_e'(wb_adr_i[4:2]);
    assign w_acc    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_acc & wb_we_i;
    assign w_rd     = w_acc & ~wb_we_i;
    assign w_tick   = r_en && (r_pcnt == r_div);
    assign w_wr_lo  = w_wr && (w_off == OFF_MTIME_LO);
    assign w_wr_hi  = w_wr && (w_off == OFF_MTIME_HI);
    assign w_unused = &{1'b0, wb_adr_i};

    // A bus write to one half wins over the tick for that half; a lo write
    // also suppresses the carry into hi.
    always_comb begin
        w_lo_nxt = r_mtime_lo;
        w_hi_nxt = r_mtime_hi;
        if (w_wr_lo) begin
            w_lo_nxt = f_merge(r_mtime_lo, wb_dat_i, wb_sel_i);
        end else if (w_tick) begin
            w_lo_nxt = r_mtime_lo + 32'd1;
        end
        if (w_wr_hi) begin
            w_hi_nxt = f_merge(r_mtime_hi, wb_dat_i, wb_sel_i);
        end else if (w_tick && !w_wr_lo && (r_mtime_lo == '1)) begin
            w_hi_nxt = r_mtime_hi + 32'd1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_MTIME_LO: w_rdata = r_mtime_lo;
            OFF_MTIME_HI: w_rdata = r_hi_shadow;
            OFF_CMP_LO:   w_rdata = r_cmp[31:0];
            OFF_CMP_HI:   w_rdata = r_cmp[63:32];
            OFF_CTRL:     w_rdata = {16'd0, r_div, 7'd0, r_en};
            OFF_MSIP:     w_rdata = {31'd0, r_msip};
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime_lo  <= '0;
            r_mtime_hi  <= '0;
            r_cmp       <= CMP_RESET;
            r_en        <= 1'b0;
            r_div       <= '0;
            r_pcnt      <= '0;
            r_msip      <= 1'b0;
            r_hi_shadow <= '0;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_tirq      <= 1'b0;
        end else begin
            r_ack      <= w_acc;
            r_tirq     <= ({r_mtime_hi, r_mtime_lo} >= r_cmp);
            r_mtime_lo <= w_lo_nxt;
            r_mtime_hi <= w_hi_nxt;

            if (w_rd) begin
                r_dat <= w_rdata;
                if (w_off == OFF_MTIME_LO) r_hi_shadow <= r_mtime_hi;
            end

            if (w_wr && (w_off == OFF_CTRL)) begin
                r_pcnt <= '0;
            end else if (r_en) begin
                r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
            end

            if (w_wr) begin
                case (w_off)
                    OFF_CMP_LO: r_cmp[31:0]  <= f_merge(r_cmp[31:0], wb_dat_i, wb_sel_i);
                    OFF_CMP_HI: r_cmp[63:32] <= f_merge(r_cmp[63:32], wb_dat_i, wb_sel_i);
                    OFF_CTRL: begin
                        if (wb_sel_i[0]) r_en  <= wb_dat_i[0];
                        if (wb_sel_i[1]) r_div <= wb_dat_i[15:8];
                    end
                    OFF_MSIP: begin
                        if (wb_sel_i[0]) r_msip <= wb_dat_i[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wb_dat_o  = r_dat;
    assign wb_ack_o  = r_ack;
    assign timer_irq = r_tirq;
    assign soft_irq  = r_msip;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a 64-bit behavioural model.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic        tirq;
    logic        sirq;

    int n_tests = 0;
    int n_fail  = 0;

    machine_timer #(.ADDR_W(8), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .timer_irq(tirq), .soft_irq(sirq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Behavioural model: mtime as one 64-bit number
    logic [63:0] m_mtime, m_cmp, m_next;
    logic        m_en, m_msip, m_ack, m_rd, m_irq;
    logic [7:0]  m_div, m_pcnt;
    logic [31:0] m_shadow, m_dat, m_rv;
    logic        m_acc, m_wr, m_tick;
    int          m_off;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mtime = '0; m_cmp = '1; m_en = 0; m_div = '0; m_pcnt = '0;
            m_msip = 0; m_shadow = '0; m_ack = 0; m_rd = 0; m_dat = '0; m_irq = 0;
        end else begin
            m_acc  = cyc && stb && !m_ack;
            m_wr   = m_acc && we;
            m_off  = int'(adr[4:2]);
            m_tick = m_en && (m_pcnt == m_div);
            case (m_off)
                0: m_rv = m_mtime[31:0];
                1: m_rv = m_shadow;
                2: m_rv = m_cmp[31:0];
                3: m_rv = m_cmp[63:32];
                4: m_rv = {16'd0, m_div, 7'd0, m_en};
                5: m_rv = {31'd0, m_msip};
                default: m_rv = '0;
            endcase
            m_irq = (m_mtime >= m_cmp);
            if (m_acc && !we && m_off == 0) m_shadow = m_mtime[63:32];
            if (m_acc && !we) m_dat = m_rv;
            m_rd  = m_acc && !we;
            m_ack = m_acc;

            if (m_wr && m_off == 0)
                m_next = {m_mtime[63:32], merge(m_mtime[31:0], dat_i, sel)};
            else if (m_wr && m_off == 1)
                m_next = {merge(m_mtime[63:32], dat_i, sel), m_mtime[31:0] + {31'd0, m_tick}};
            else
                m_next = m_mtime + {63'd0, m_tick};
            m_mtime = m_next;

            if (m_wr && m_off == 4) m_pcnt = '0;
            else if (m_en) m_pcnt = m_tick ? 8'd0 : m_pcnt + 8'd1;

            if (m_wr) begin
                if (m_off == 2) m_cmp[31:0]  = merge(m_cmp[31:0], dat_i, sel);
                if (m_off == 3) m_cmp[63:32] = merge(m_cmp[63:32], dat_i, sel);
                if (m_off == 4 && sel[0]) m_en  = dat_i[0];
                if (m_off == 4 && sel[1]) m_div = dat_i[15:8];
                if (m_off == 5 && sel[0]) m_msip = dat_i[0];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            chk("ack", {63'd0, ack}, {63'd0, m_ack});
            if (m_ack && m_rd) chk("rdata", {32'd0, dat_o}, {32'd0, m_dat});
            chk("timer_irq", {63'd0, tirq}, {63'd0, m_irq});
            chk("soft_irq", {63'd0, sirq}, {63'd0, m_msip});
        end
    end

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = a;
        @(negedge clk);
        d = dat_o;
        cyc = 0; stb = 0;
    endtask

    logic [31:0] rd, rd2;
    int          nack;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;

        // Reset values
        chk("rst_tirq", {63'd0, tirq}, 64'd0);
        chk("rst_sirq", {63'd0, sirq}, 64'd0);
        wb_read(8'h00, rd); chk("rst_mtime_lo", {32'd0, rd}, 64'h0);
        wb_read(8'h04, rd); chk("rst_mtime_hi", {32'd0, rd}, 64'h0);
        wb_read(8'h08, rd); chk("rst_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
        wb_read(8'h0C, rd); chk("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        wb_read(8'h10, rd); chk("rst_ctrl", {32'd0, rd}, 64'h0);
        wb_read(8'h14, rd); chk("rst_msip", {32'd0, rd}, 64'h0);

        // Prescale: div=3 over 41 enabled edges gives 10 ticks
        wb_write(8'h10, 32'h0000_0301, 4'hF);
        repeat (39) @(negedge clk);
        wb_write(8'h10, 32'h0, 4'hF);
        wb_read(8'h00, rd); chk("prescale_div3", {32'd0, rd}, 64'd10);
        wb_write(8'h10, 32'h0000_0001, 4'hF);
        repeat (18) @(negedge clk);
        wb_write(8'h10, 32'h0, 4'hF);
        wb_read(8'h00, rd); chk("prescale_div0", {32'd0, rd}, 64'd30);
        repeat (5) @(negedge clk);
        wb_read(8'h00, rd); chk("frozen", {32'd0, rd}, 64'd30);

        // Wrap and coherent read
        wb_write(8'h04, 32'h0, 4'hF);
        wb_write(8'h00, 32'hFFFF_FFFE, 4'hF);
        wb_write(8'h10, 32'h1, 4'hF);
        wb_read(8'h00, rd);
        wb_read(8'h04, rd2);
        chk("coherent_pair", {rd2, rd}, 64'h0000_0000_FFFF_FFFF);
        wb_write(8'h10, 32'h0, 4'hF);
        wb_read(8'h00, rd);
        wb_read(8'h04, rd2);
        chk("wrapped_pair", {rd2, rd}, 64'h0000_0001_0000_0004);

        // Compare
        wb_write(8'h0C, 32'h0, 4'hF);
        wb_write(8'h08, 32'd100, 4'hF);
        wb_write(8'h04, 32'h0, 4'hF);
        wb_write(8'h00, 32'd90, 4'hF);
        wb_write(8'h10, 32'h1, 4'hF);
        repeat (10) @(posedge clk);
        #1 chk("irq_before", {63'd0, tirq}, 64'd0);
        @(posedge clk);
        #1 chk("irq_rise", {63'd0, tirq}, 64'd1);
        wb_write(8'h08, 32'd1000, 4'hF);
        chk("irq_hold_on_write", {63'd0, tirq}, 64'd1);
        @(posedge clk);
        #1 chk("irq_drop", {63'd0, tirq}, 64'd0);
        wb_write(8'h10, 32'h0, 4'hF);

        // Software IRQ and byte lanes
        wb_write(8'h14, 32'h1, 4'b0001);
        chk("msip_set", {63'd0, sirq}, 64'd1);
        wb_write(8'h14, 32'h0, 4'b0010);
        chk("msip_lane", {63'd0, sirq}, 64'd1);
        wb_write(8'h14, 32'h0, 4'b1111);
        chk("msip_clr", {63'd0, sirq}, 64'd0);

        // Held strobe on reserved offset
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 8'h1C;
        nack = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack) begin
                nack++;
                chk("rsvd_read", {32'd0, dat_o}, 64'd0);
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0;
        chk("held_acks", 64'(nack), 64'd3);

        // Async reset mid-ack
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 8'h08;
        @(posedge clk);
        #1 chk("ack_before_rst", {63'd0, ack}, 64'd1);
        #2 reset_n = 0;
        #1 chk("ack_async_clr", {63'd0, ack}, 64'd0);
        cyc = 0; stb = 0;
        @(negedge clk);
        reset_n = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc   = ($urandom_range(0, 9) < 7);
            stb   = ($urandom_range(0, 9) < 8);
            we    = $urandom_range(0, 1);
            adr   = 8'($urandom);
            dat_i = $urandom;
            sel   = 4'($urandom);
            if (adr[4:2] == 3'd4) dat_i[15:8] = 8'($urandom_range(0, 3));
            if (adr[4:2] == 3'd1 || adr[4:2] == 3'd3) dat_i = 32'($urandom_range(0, 1));
            if (adr[4:2] == 3'd2 && $urandom_range(0, 1) == 1) dat_i = 32'($urandom_range(0, 200));
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer and software-interrupt source for the SoC. It holds the 64-bit `mtime` counter, the `mtimecmp` compare value and the `msip` bit, all accessible over a Wishbone-classic slave port. It drives the `timer_irq` and `soft_irq` levels consumed by the core's machine-mode CSR file, which latches them into `mip` bits 7 and 3.

## Interface
- `ADDR_W`, default 8: byte-address width of the slave port.
- `CMP_RESET`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`. With this default no timer IRQ is raised out of reset.

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `wb_cyc_i`, input, 1: bus cycle valid.
- `wb_stb_i`, input, 1: strobe.
- `wb_we_i`, input, 1: 1 = write, 0 = read.
- `wb_adr_i`, input, ADDR_W: byte address. Only bits [4:2] are decoded.
- `wb_dat_i`, input, 32: write data.
- `wb_sel_i`, input, 4: byte enables for writes.
- `wb_dat_o`, output, 32: read data, registered.
- `wb_ack_o`, output, 1: transfer acknowledge, registered.
- `timer_irq`, output, 1: machine timer interrupt level, registered.
- `soft_irq`, output, 1: machine software interrupt level; equals `msip`.

## Operation
- Register map (word offsets):
  - 0x00 `mtime_lo`.
  - 0x04 `mtime_hi`.
  - 0x08 `mtimecmp_lo`.
  - 0x0C `mtimecmp_hi`.
  - 0x10 `ctrl`: bit0 `en`, bits[15:8] `div`. All other bits read 0.
  - 0x14 `msip`: bit0. All other bits read 0.
  - Offsets 0x18 and 0x1C: reads return 0, writes are ignored, and the access is still acked.
- Writes apply per byte lane according to `wb_sel_i`. Read-only bits ignore writes.
- Prescaler:
  - An 8-bit `pcnt` counts cycles while `en`=1.
  - When `pcnt == div`, a tick fires, `pcnt` returns to 0 and `mtime` increments by 1.
  - With `div`=0, `mtime` increments every cycle. With `en`=0, `pcnt` and `mtime` hold.
  - Any write to `ctrl` clears `pcnt` to 0.
- `mtime` is a 64-bit increment that wraps from 2^64-1 to 0, with the carry propagating from lo into hi.
- Bus write to `mtime_lo` or `mtime_hi` in the same cycle as a tick: the written half takes the bus value and the tick is dropped for that half.
  - A write to lo does not carry into hi.
  - A write to hi leaves lo free to increment, but with no carry into hi on that cycle.
- Coherent 64-bit read: a read of `mtime_lo` latches the current `mtime[63:32]` into a `hi_shadow` register. A read of `mtime_hi` returns `hi_shadow`, not the live value. `hi_shadow` resets to 0.
- `timer_irq` is registered each cycle as (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of the current register values. The compare is independent of `en`.
- `timer_irq` is a level, not a pulse. Software clears it by writing `mtimecmp` above `mtime`.

## Timing
- Reset values:
  - `mtime`=0, `mtimecmp`=CMP_RESET, `ctrl`=0, `msip`=0, `pcnt`=0.
  - `wb_ack_o`=0, `wb_dat_o`=0, `timer_irq`=0, `soft_irq`=0.
- Bus handshake:
  - When `wb_cyc_i & wb_stb_i & ~wb_ack_o` is seen at a rising edge, `wb_ack_o`=1 for exactly one cycle.
  - Read data in `wb_dat_o` is valid in that same cycle.
  - Writes take effect at that same edge.
  - `wb_ack_o` drops the following cycle even if `wb_stb_i` stays high. A held strobe therefore gets an ack every other cycle.
- Read data is sampled at the acking edge, i.e. the pre-update value, including the `mtime` value before that edge's tick.
- `timer_irq` latency: one cycle after the register state satisfies the compare. After a `mtimecmp` write that clears the condition, it deasserts on the edge after the write edge.
- `soft_irq` follows `msip` with zero added latency; `msip` is a flop.
- An asynchronous reset mid-transfer clears `ack` immediately. The master must restart the transfer.

## Test plan
- Reset: hold `reset_n`=0 and release. Reading offsets 0x00 to 0x14 returns 0, 0, FFFFFFFF, FFFFFFFF, 0, 0. `timer_irq`=0 and `soft_irq`=0.
- Prescale: write `ctrl`=0x0301 (en=1, div=3) and idle 40 cycles. `mtime` advances by exactly 10. `ctrl`=0x0001 advances it 1 per cycle. `ctrl`=0 freezes it.
- Wrap/coherent read: write `mtime_hi`=0, `mtime_lo`=FFFFFFFE, `ctrl`=1. Read lo then hi across the carry. The (hi,lo) pair is consistent, e.g. (1,0x00000001) or (0,0xFFFFFFFF), never (0,small).
- Compare: set `mtimecmp`={0,100}, `mtime`=90, en=1, div=0. `timer_irq` rises exactly one cycle after `mtime` reaches 100. Writing `mtimecmp_lo`=1000 drops it one cycle later.
- Software IRQ and byte lanes: write `msip`=1 with `wb_sel_i`=0001, giving `soft_irq`=1. Write with `wb_sel_i`=0010 leaves it unchanged. Writing 0 clears it.
- Handshake: hold `wb_stb_i` high for 6 cycles. This produces 3 single-cycle acks. An access to 0x1C acks and reads 0. Asserting `reset_n`=0 mid-ack clears `wb_ack_o` immediately.
